pipe_scroller: RTL and testbench

PIPE_SCROLLER -- requirements
Module: pipe_scroller

---
 rtl/pipe_pkg.sv | 19 +
 rtl/lfsr8.sv | 30 +++
 rtl/pipe_scroller.sv | 137 +++++++++++++
 tb/tb_pipe_scroller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and defaults for the pipe scroller.
// Holds the FSM state enum, the LFSR seed and default parameters.

package pipe_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_OVER = 2'd2
   } state_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

   localparam int DEF_SCROLL_PERIOD = 8;
   localparam int DEF_PIPE_SPACING  = 4;
   localparam int DEF_GAP_H         = 4;
   localparam int DEF_BIRD_COL      = 3;

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, taps 7/5/4/3, seeded from pipe_pkg.
// Ports: clk, rst (sync, active-high), en (advance one step), q (state).

module lfsr8
   import pipe_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [7:0] q
);

   logic [7:0] r_q;
   logic       w_fb;

   // Taps give a maximal-length sequence, so the all-zero
   // lock-up state is never reached from a nonzero seed.
   assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= LFSR_SEED;
      end else if (en) begin
         r_q <= {r_q[6:0], w_fb};
      end
   end

   assign q = r_q;

endmodule

// File: rtl/pipe_scroller.sv
// pipe_scroller: 16x16 playfield that scrolls pipes toward column 0.
// Ports: clk, rst (sync, active-high), start, gameover (levels);
// green_array[c][r] playfield, green_column = column BIRD_COL,
// scroll_tick = registered pulse in the cycle after each step.

module pipe_scroller
   import pipe_pkg::*;
#(
   parameter int SCROLL_PERIOD = DEF_SCROLL_PERIOD,
   parameter int PIPE_SPACING  = DEF_PIPE_SPACING,
   parameter int GAP_H         = DEF_GAP_H,
   parameter int BIRD_COL      = DEF_BIRD_COL
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              gameover,
   output logic [15:0][15:0] green_array,
   output logic [15:0]       green_column,
   output logic              scroll_tick
);

   localparam logic [7:0]  PRESC_LAST = 8'(SCROLL_PERIOD - 1);
   localparam logic [7:0]  SPAWN_LAST = 8'(PIPE_SPACING - 1);
   localparam logic [4:0]  G_MAX      = 5'(16 - GAP_H);
   localparam logic [15:0] GAP_MASK   =
      16'((32'd1 << GAP_H) - 32'd1);

   state_t r_state;
   state_t w_state_nxt;

   logic [15:0][15:0] r_array;
   logic [7:0]        r_presc;
   logic [7:0]        r_spawn;
   logic              r_tick;

   logic              w_run_act;
   logic              w_step;
   logic [7:0]        w_lfsr;
   logic [4:0]        w_g;
   logic [15:0]       w_pipe;
   logic [15:0]       w_new;
   logic [3:0]        w_unused_lfsr_hi;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_run_act   = 1'b0;
      w_step      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (gameover) begin
               w_state_nxt = S_OVER;
            end else begin
               w_run_act = 1'b1;
               w_step    = (r_presc == PRESC_LAST);
            end
         end
         S_OVER: begin
            w_state_nxt = S_OVER;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------- pipe generation ----------------
   lfsr8 u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (w_step),
      .q   (w_lfsr)
   );

   assign w_unused_lfsr_hi = w_lfsr[7:4];

   // Gap start is clamped so the gap always fits inside the column.
   always_comb begin
      w_g = {1'b0, w_lfsr[3:0]};
      if (w_g > G_MAX) begin
         w_g = G_MAX;
      end
      w_pipe = ~(GAP_MASK << w_g);
      w_new  = 16'h0000;
      if (r_spawn == SPAWN_LAST) begin
         w_new = w_pipe;
      end
   end

   // ---------------- datapath ----------------
   // Prescaler only moves while running with no gameover, so a
   // gameover both suppresses the due step and freezes the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_array <= '0;
         r_presc <= 8'd0;
         r_spawn <= 8'd0;
         r_tick  <= 1'b0;
      end else begin
         r_tick <= w_step;
         if (w_run_act) begin
            if (w_step) begin
               r_presc <= 8'd0;
            end else begin
               r_presc <= r_presc + 8'd1;
            end
         end
         if (w_step) begin
            r_array <= {w_new, r_array[15:1]};
            if (r_spawn == SPAWN_LAST) begin
               r_spawn <= 8'd0;
            end else begin
               r_spawn <= r_spawn + 8'd1;
            end
         end
      end
   end

   assign green_array  = r_array;
   assign green_column = r_array[BIRD_COL];
   assign scroll_tick  = r_tick;

endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller: directed + randomized check of pipe_scroller
// against a step-counting behavioural model of the playfield.

module tb_pipe_scroller;

   localparam int P    = 8;
   localparam int S    = 4;
   localparam int GAP  = 4;
   localparam int BIRD = 3;

   logic              clk;
   logic              rst;
   logic              start;
   logic              gameover;
   logic [15:0][15:0] green_array;
   logic [15:0]       green_column;
   logic              scroll_tick;

   int total = 0;
   int bad   = 0;

   pipe_scroller #(
      .SCROLL_PERIOD (P),
      .PIPE_SPACING  (S),
      .GAP_H         (GAP),
      .BIRD_COL      (BIRD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .gameover     (gameover),
      .green_array  (green_array),
      .green_column (green_column),
      .scroll_tick  (scroll_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   // ms: 0 idle, 1 run, 2 over. mk counts active run edges,
   // every P-th one is a step; mn counts steps taken.
   int                ms = 0;
   int                mk = 0;
   int                mn = 0;
   logic [15:0][15:0] m_arr = '0;
   logic              m_tick = 1'b0;

   function automatic logic [7:0] lfsr_at(input int n);
      logic [7:0] v;
      v = 8'hA5;
      for (int i = 1; i < n; i++) begin
         v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      end
      return v;
   endfunction

   function automatic logic [15:0] pipe_of(input logic [7:0] l);
      int          g;
      logic [15:0] c;
      g = int'(l[3:0]);
      if (g > 16 - GAP) g = 16 - GAP;
      c = 16'hFFFF;
      for (int r = g; r < g + GAP; r++) c[r] = 1'b0;
      return c;
   endfunction

   always @(posedge clk) begin
      logic [15:0] nc;
      if (rst) begin
         ms = 0; mk = 0; mn = 0;
         m_arr = '0; m_tick = 1'b0;
      end else begin
         m_tick = 1'b0;
         case (ms)
            0: if (start) begin ms = 1; mk = 0; end
            1: begin
               if (gameover) begin
                  ms = 2;
               end else begin
                  mk++;
                  if (mk % P == 0) begin
                     mn++;
                     nc = (mn % S == 0) ? pipe_of(lfsr_at(mn)) : 16'h0;
                     for (int c = 0; c < 15; c++) m_arr[c] = m_arr[c+1];
                     m_arr[15] = nc;
                     m_tick = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("array", green_array, m_arr);
      chk("column", green_column, m_arr[BIRD]);
      chk("tick", scroll_tick, m_tick);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_step(input int n, input string nm);
      int budget;
      budget = 4000;
      while (mn < n && budget > 0) begin
         cyc();
         budget--;
      end
      chk(nm, (mn >= n), 1'b1);
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int                first;
      int                budget;
      logic [15:0][15:0] frz;

      rst = 1'b1; start = 1'b0; gameover = 1'b0;
      chk("pin_lfsr4", lfsr_at(4), 8'h2A);
      chk("pin_clamp", pipe_of(8'h0F), 16'h0FFF);
      chk("pin_pipe1", pipe_of(8'h2A), 16'hC3FF);
      cyc(); cyc();
      rst = 1'b0;

      // idle with gameover toggling must stay blank
      for (int i = 0; i < 50; i++) begin
         gameover = (i % 7 == 3);
         cyc();
      end
      gameover = 1'b0;
      @(negedge clk);
      chk("idle_array", green_array, '0);
      chk("idle_tick", scroll_tick, 1'b0);

      // first run: tick in RUN cycle 9
      start = 1'b1;
      cyc();
      start = 1'b0;
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (scroll_tick) begin
            first = i;
            break;
         end
      end
      chk("first_tick_cycle", first, 9);
      chk("col15_s1", green_array[15], 16'h0000);
      wait_step(2, "reach_s2");
      chk("col15_s2", green_array[15], 16'h0000);
      wait_step(3, "reach_s3");
      chk("col15_s3", green_array[15], 16'h0000);
      wait_step(4, "reach_s4");
      chk("col15_s4", green_array[15], 16'hC3FF);
      wait_step(16, "reach_s16");
      chk("bird_s16", green_column, 16'hC3FF);
      wait_step(17, "reach_s17");
      chk("bird_s17", green_column, 16'h0000);

      // gameover on a step-due cycle
      budget = 100;
      while (!(ms == 1 && (mk + 1) % P == 0) && budget > 0) begin
         cyc();
         budget--;
      end
      chk("reach_due", budget > 0, 1'b1);
      frz = m_arr;
      gameover = 1'b1;
      cyc();
      for (int i = 0; i < 4; i++) cyc();
      gameover = 1'b0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 20; i++) cyc();
      @(negedge clk);
      chk("frozen_array", green_array, frz);
      chk("frozen_tick", scroll_tick, 1'b0);

      // reset while in OVER
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_over_array", green_array, '0);
      chk("rst_over_col", green_column, 16'h0);
      chk("rst_over_tick", scroll_tick, 1'b0);

      // restart reproduces the sequence
      start = 1'b1;
      cyc();
      start = 1'b0;
      wait_step(4, "reach_re4");
      chk("restart_col15", green_array[15], 16'hC3FF);

      // reset mid-run, between steps
      wait_step(9, "reach_re9");
      for (int i = 0; i < 3; i++) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_run_array", green_array, '0);
      chk("rst_run_tick", scroll_tick, 1'b0);

      // randomized traffic
      for (int i = 0; i < 6000; i++) begin
         rst      = ($urandom_range(0, 399) == 0);
         start    = ($urandom_range(0, 15) == 0);
         gameover = ($urandom_range(0, 899) == 0);
         cyc();
      end
      rst = 1'b0; start = 1'b0; gameover = 1'b0;
      cyc();
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
